// File: rtl/mem_io_pkg.sv
// Shared types and constants for the CPU memory / IO register router.
// The DRAIN state exists only when MEM_IO_TIMEOUT_EN is defined.
package mem_io_pkg;

    localparam int unsigned DEFAULT_IO_BASE = 'h100;
    localparam logic [15:0] TIMEOUT_DATA    = 16'hDEAD;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_IO_CPLT   = 2'd1,
        ST_DRAM_WAIT = 2'd2
`ifdef MEM_IO_TIMEOUT_EN
        ,
        ST_DRAIN     = 2'd3
`endif
    } mem_io_state_t;

endpackage

// File: rtl/mem_io_regfile.sv
// Bank of NUM_IO memory-mapped IO registers with one indexed write port.
// The register contents are exported as one flat vector.
module mem_io_regfile #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_IO     = 4,
    parameter int unsigned IDX_W      = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [IDX_W-1:0]             wr_idx,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    output logic [NUM_IO*DATA_WIDTH-1:0] regs
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_IO; i++) begin
                regs[i*DATA_WIDTH +: DATA_WIDTH] <= RESET_VAL;
            end
        end else if (wr_en) begin
            for (int unsigned i = 0; i < NUM_IO; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    regs[i*DATA_WIDTH +: DATA_WIDTH] <= wr_data;
                end
            end
        end
    end

endmodule

// File: rtl/mem_io_router.sv
// Splits CPU memory requests between the DRAM mem_driver and a bank of IO registers.
// Optional DRAM watchdog (TIMEOUT_CYCLES, mem_err, DRAIN state) is enabled by MEM_IO_TIMEOUT_EN.
module mem_io_router
    import mem_io_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned NUM_IO       = 4,
    parameter int unsigned IO_BASE      = DEFAULT_IO_BASE,
    parameter logic [DATA_WIDTH-1:0] IO_RESET_VAL = '0
`ifdef MEM_IO_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ADDR_WIDTH-1:0]        mem_addr,
    input  logic [DATA_WIDTH-1:0]        mem_data_in,
    input  logic                         mem_r_en,
    input  logic                         mem_w_en,
    output logic                         mem_rdy,
    output logic                         mem_cplt,
    output logic [DATA_WIDTH-1:0]        mem_data_out,
    output logic                         dram_r_en,
    output logic                         dram_w_en,
    input  logic                         dram_rdy,
    input  logic                         dram_cplt,
    input  logic [DATA_WIDTH-1:0]        dram_data_out,
    output logic [NUM_IO*DATA_WIDTH-1:0] io_regs,
    output logic [NUM_IO-1:0]            io_wr_stb
`ifdef MEM_IO_TIMEOUT_EN
    ,
    output logic                         mem_err
`endif
);

    localparam int unsigned IDX_W = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
    localparam logic [ADDR_WIDTH:0]   BASE_EXT  = (ADDR_WIDTH+1)'(IO_BASE);
    localparam logic [ADDR_WIDTH:0]   LIMIT_EXT = BASE_EXT + (ADDR_WIDTH+1)'(NUM_IO);
    localparam logic [ADDR_WIDTH-1:0] BASE_A    = ADDR_WIDTH'(IO_BASE);

    mem_io_state_t state, state_next;

    logic                  io_hit;
    logic [IDX_W-1:0]      io_idx;
    logic [IDX_W-1:0]      idx_q;
    logic                  accept;
    logic                  is_write;
    logic                  io_wr_en;
    logic [DATA_WIDTH-1:0] rd_data;

    // Decode is done one bit wider so a window near the top of the map cannot wrap.
    assign io_hit   = ({1'b0, mem_addr} >= BASE_EXT) && ({1'b0, mem_addr} < LIMIT_EXT);
    assign io_idx   = IDX_W'(mem_addr - BASE_A);
    assign accept   = (state == ST_IDLE) && dram_rdy && (mem_r_en || mem_w_en);
    assign is_write = mem_w_en && !mem_r_en;
    assign io_wr_en = accept && io_hit && is_write;

    mem_io_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_IO     (NUM_IO),
        .IDX_W      (IDX_W),
        .RESET_VAL  (IO_RESET_VAL)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (io_wr_en),
        .wr_idx  (io_idx),
        .wr_data (mem_data_in),
        .regs    (io_regs)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx_q     <= '0;
            io_wr_stb <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                idx_q <= io_idx;
            end
            for (int unsigned i = 0; i < NUM_IO; i++) begin
                io_wr_stb[i] <= io_wr_en && (io_idx == IDX_W'(i));
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < NUM_IO; i++) begin
            if (idx_q == IDX_W'(i)) begin
                rd_data = io_regs[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef MEM_IO_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt;
    logic             timeout;

    // Counter holds zero outside DRAM_WAIT, so it restarts on every entry.
    assign timeout = (state == ST_DRAM_WAIT) && !dram_cplt &&
                     (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt  <= '0;
            mem_err <= 1'b0;
        end else begin
            if (state == ST_DRAM_WAIT) begin
                wd_cnt <= wd_cnt + 1'b1;
            end else begin
                wd_cnt <= '0;
            end
            if (timeout) begin
                mem_err <= 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_next   = state;
        mem_rdy      = 1'b0;
        mem_cplt     = 1'b0;
        mem_data_out = '0;
        dram_r_en    = 1'b0;
        dram_w_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                mem_rdy   = dram_rdy;
                dram_r_en = mem_r_en && !io_hit;
                dram_w_en = is_write && !io_hit;
                if (accept) begin
                    state_next = io_hit ? ST_IO_CPLT : ST_DRAM_WAIT;
                end
            end
            ST_IO_CPLT: begin
                mem_cplt     = 1'b1;
                mem_data_out = rd_data;
                state_next   = ST_IDLE;
            end
            ST_DRAM_WAIT: begin
                mem_cplt     = dram_cplt;
                mem_data_out = dram_data_out;
                if (dram_cplt) begin
                    state_next = ST_IDLE;
                end
`ifdef MEM_IO_TIMEOUT_EN
                else if (timeout) begin
                    mem_cplt     = 1'b1;
                    mem_data_out = DATA_WIDTH'(TIMEOUT_DATA);
                    state_next   = ST_DRAIN;
                end
`endif
            end
`ifdef MEM_IO_TIMEOUT_EN
            ST_DRAIN: begin
                if (dram_cplt) begin
                    state_next = ST_IDLE;
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_io_router.sv
// Directed self-checking bench for mem_io_router (watchdog steps run when MEM_IO_TIMEOUT_EN is defined).
module tb_mem_io_router;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_in;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        mem_rdy;
    logic        mem_cplt;
    logic [15:0] mem_data_out;
    logic        dram_r_en;
    logic        dram_w_en;
    logic        dram_rdy;
    logic        dram_cplt;
    logic [15:0] dram_data_out;
    logic [63:0] io_regs;
    logic [3:0]  io_wr_stb;
`ifdef MEM_IO_TIMEOUT_EN
    logic        mem_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_io_router #(
        .ADDR_WIDTH     (16),
        .DATA_WIDTH     (16),
        .NUM_IO         (4),
        .IO_BASE        ('h100),
        .IO_RESET_VAL   (16'h0000)
`ifdef MEM_IO_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (8)
`endif
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_addr      (mem_addr),
        .mem_data_in   (mem_data_in),
        .mem_r_en      (mem_r_en),
        .mem_w_en      (mem_w_en),
        .mem_rdy       (mem_rdy),
        .mem_cplt      (mem_cplt),
        .mem_data_out  (mem_data_out),
        .dram_r_en     (dram_r_en),
        .dram_w_en     (dram_w_en),
        .dram_rdy      (dram_rdy),
        .dram_cplt     (dram_cplt),
        .dram_data_out (dram_data_out),
        .io_regs       (io_regs),
        .io_wr_stb     (io_wr_stb)
`ifdef MEM_IO_TIMEOUT_EN
        ,
        .mem_err       (mem_err)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        mem_addr      = '0;
        mem_data_in   = '0;
        mem_r_en      = 1'b0;
        mem_w_en      = 1'b0;
        dram_rdy      = 1'b1;
        dram_cplt     = 1'b0;
        dram_data_out = '0;

        // Reset state
        #2;
        check("rst_io_regs", io_regs, 64'h0);
        check("rst_cplt", mem_cplt, 1'b0);
        check("rst_data", mem_data_out, 16'h0);
        check("rst_stb", io_wr_stb, 4'b0000);
        step();
        step();
        rst_n = 1'b1;
        #1;
        check("rdy_after_rst", mem_rdy, 1'b1);
        dram_rdy = 1'b0;
        #1;
        check("rdy_follows_dram", mem_rdy, 1'b0);
        dram_rdy = 1'b1;
        step();

        // IO write 'h1234 to 'h102
        mem_addr = 16'h0102; mem_data_in = 16'h1234; mem_w_en = 1'b1;
        #1;
        check("iow_dram_w", dram_w_en, 1'b0);
        check("iow_dram_r", dram_r_en, 1'b0);
        step();
        mem_w_en = 1'b0;
        check("iow_cplt", mem_cplt, 1'b1);
        check("iow_data", mem_data_out, 16'h1234);
        check("iow_stb", io_wr_stb, 4'b0100);
        check("iow_regs", io_regs, 64'h0000_1234_0000_0000);
        check("iow_busy", mem_rdy, 1'b0);
        step();
        check("iow_cplt_end", mem_cplt, 1'b0);
        check("iow_stb_end", io_wr_stb, 4'b0000);
        check("iow_rdy_back", mem_rdy, 1'b1);

        // IO read 'h102
        mem_r_en = 1'b1;
        #1;
        check("ior_dram_r", dram_r_en, 1'b0);
        step();
        mem_r_en = 1'b0;
        check("ior_cplt", mem_cplt, 1'b1);
        check("ior_data", mem_data_out, 16'h1234);
        check("ior_stb", io_wr_stb, 4'b0000);
        step();

        // DRAM read 'h0200, completion on the 5th waiting cycle
        mem_addr = 16'h0200; mem_r_en = 1'b1;
        #1;
        check("dr_dram_r", dram_r_en, 1'b1);
        step();
        mem_r_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("dr_wait_rdy", mem_rdy, 1'b0);
            check("dr_wait_cplt", mem_cplt, 1'b0);
            step();
        end
        dram_cplt = 1'b1; dram_data_out = 16'hBEEF;
        #1;
        check("dr_rdy_at_cplt", mem_rdy, 1'b0);
        check("dr_cplt", mem_cplt, 1'b1);
        check("dr_data", mem_data_out, 16'hBEEF);
        step();
        dram_cplt = 1'b0;
        #1;
        check("dr_rdy_back", mem_rdy, 1'b1);
        check("dr_cplt_end", mem_cplt, 1'b0);

        // dram_cplt while idle is ignored
        dram_cplt = 1'b1; dram_data_out = 16'h5555;
        #1;
        check("idle_cplt_ignored", mem_cplt, 1'b0);
        step();
        dram_cplt = 1'b0;

        // Address decode boundaries, observed with dram_rdy low so nothing is accepted
        dram_rdy = 1'b0; mem_r_en = 1'b1;
        mem_addr = 16'h0104; #1;
        check("bnd_104_dram", dram_r_en, 1'b1);
        mem_addr = 16'h00FF; #1;
        check("bnd_0ff_dram", dram_r_en, 1'b1);
        mem_addr = 16'h0100; #1;
        check("bnd_100_io", dram_r_en, 1'b0);
        check("bnd_rdy_low", mem_rdy, 1'b0);
        mem_r_en = 1'b0; dram_rdy = 1'b1;
        step();

        // Write reg 0 at 'h100
        mem_addr = 16'h0100; mem_data_in = 16'hA5A5; mem_w_en = 1'b1;
        step();
        mem_w_en = 1'b0;
        check("r0_cplt", mem_cplt, 1'b1);
        check("r0_data", mem_data_out, 16'hA5A5);
        check("r0_stb", io_wr_stb, 4'b0001);
        step();

        // r_en and w_en together at 'h101 is a read
        mem_addr = 16'h0101; mem_data_in = 16'hFFFF; mem_r_en = 1'b1; mem_w_en = 1'b1;
        #1;
        check("rw_dram_w", dram_w_en, 1'b0);
        check("rw_dram_r", dram_r_en, 1'b0);
        step();
        mem_r_en = 1'b0; mem_w_en = 1'b0;
        check("rw_cplt", mem_cplt, 1'b1);
        check("rw_data", mem_data_out, 16'h0000);
        check("rw_stb", io_wr_stb, 4'b0000);
        check("rw_regs", io_regs, 64'h0000_1234_0000_A5A5);
        step();

`ifdef MEM_IO_TIMEOUT_EN
        // Watchdog: DRAM never answers within 8 cycles
        check("to_err_init", mem_err, 1'b0);
        mem_addr = 16'h0300; mem_r_en = 1'b1;
        step();
        mem_r_en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check("to_wait_cplt", mem_cplt, 1'b0);
            step();
        end
        check("to_cplt", mem_cplt, 1'b1);
        check("to_data", mem_data_out, 16'hDEAD);
        step();
        check("to_err", mem_err, 1'b1);
        check("to_drain_rdy", mem_rdy, 1'b0);
        check("to_drain_cplt", mem_cplt, 1'b0);
        step();
        dram_cplt = 1'b1; dram_data_out = 16'h7777;
        #1;
        check("to_late_swallowed", mem_cplt, 1'b0);
        step();
        dram_cplt = 1'b0;
        #1;
        check("to_idle_rdy", mem_rdy, 1'b1);
        check("to_err_sticky", mem_err, 1'b1);
        step();
`endif

        // Reset in the middle of a DRAM transaction
        mem_addr = 16'h0400; mem_r_en = 1'b1;
        step();
        mem_r_en = 1'b0;
        step();
        rst_n = 1'b0;
        dram_cplt = 1'b1;
        #1;
        check("mid_rst_cplt", mem_cplt, 1'b0);
        check("mid_rst_regs", io_regs, 64'h0);
        step();
        dram_cplt = 1'b0;
        rst_n = 1'b1;
        #1;
        check("mid_rst_rdy", mem_rdy, 1'b1);
        check("mid_rst_cplt_after", mem_cplt, 1'b0);
`ifdef MEM_IO_TIMEOUT_EN
        check("mid_rst_err_clr", mem_err, 1'b0);
`endif
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
